// File: rtl/ofifo_pkg.sv
// Shared defaults for the output-side psum collector.
package ofifo_pkg;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned PTR_W   = $clog2(DEPTH) + 1;

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane circular FIFO with wrap-bit pointers and a combinational head.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int unsigned bw    = PSUM_BW,
  parameter int unsigned depth = DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out_data,
  output logic          o_empty,
  output logic          o_full
);

  localparam int unsigned AW = $clog2(depth);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [bw-1:0] r_mem [depth];

  logic w_wr_en;
  logic w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A full lane still takes a write when the same cycle pops it.
  assign w_rd_en = rd & ~o_empty & ~reset;
  assign w_wr_en = wr & (~o_full | w_rd_en) & ~reset;

  assign out_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= in;
  end

endmodule

// File: rtl/ofifo.sv
// Collects per-column psums into aligned col-wide vectors for the psum SRAM.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned col   = COL,
  parameter int unsigned bw    = PSUM_BW,
  parameter int unsigned depth = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready
);

  logic [col-1:0]    w_empty;
  logic [col-1:0]    w_full;
  logic [col*bw-1:0] w_head;
  logic              w_pop;
  logic [col*bw-1:0] r_out;

  // Every lane pops together so column alignment is never lost.
  assign w_pop = rd & o_valid;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(
      .bw    (bw),
      .depth (depth)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr[g]),
      .rd       (w_pop),
      .in       (in[g*bw +: bw]),
      .out_data (w_head[g*bw +: bw]),
      .o_empty  (w_empty[g]),
      .o_full   (w_full[g])
    );
  end

  assign o_valid = &(~w_empty);
  assign o_full  = |w_full;
  assign o_ready = ~|w_full;
  assign out     = r_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_pop) begin
      r_out <= w_head;
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// Scoreboard bench for ofifo: per-lane reference queues feed an expected-vector queue.
module tb_ofifo;
  import ofifo_pkg::*;

  localparam int unsigned W = COL * PSUM_BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;

  always #5 clk = ~clk;

  ofifo #(
    .col   (COL),
    .bw    (PSUM_BW),
    .depth (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .wr      (wr),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready)
  );

  logic [PSUM_BW-1:0] lane_q [COL][$];
  logic [W-1:0]       exp_q[$];
  logic [W-1:0]       model_out;
  int                 checks;
  int                 failures;
  int                 pops;
  string              phase;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare outputs and flags.
  task automatic step(input logic rst, input logic [COL-1:0] w, input logic [W-1:0] d,
                      input logic r);
    logic         all_ne;
    logic         any_full;
    logic         pop;
    logic [W-1:0] vec;
    reset = rst;
    wr    = w;
    in    = d;
    rd    = r;
    @(posedge clk);
    pop = 1'b0;
    vec = '0;
    if (rst) begin
      for (int i = 0; i < COL; i++) lane_q[i].delete();
      exp_q.delete();
      model_out = '0;
    end else begin
      all_ne = 1'b1;
      for (int i = 0; i < COL; i++) if (lane_q[i].size() == 0) all_ne = 1'b0;
      pop = r && all_ne;
      if (pop) begin
        for (int i = 0; i < COL; i++) vec[i*PSUM_BW +: PSUM_BW] = lane_q[i].pop_front();
        exp_q.push_back(vec);
      end
      for (int i = 0; i < COL; i++)
        if (w[i] && lane_q[i].size() < DEPTH) lane_q[i].push_back(d[i*PSUM_BW +: PSUM_BW]);
    end
    #1;
    if (pop) begin
      model_out = exp_q.pop_front();
      pops++;
    end
    check_val("out", out, model_out);
    all_ne   = 1'b1;
    any_full = 1'b0;
    for (int i = 0; i < COL; i++) begin
      if (lane_q[i].size() == 0) all_ne = 1'b0;
      if (lane_q[i].size() == DEPTH) any_full = 1'b1;
    end
    check_val("o_valid", W'(o_valid), W'(all_ne));
    check_val("o_full", W'(o_full), W'(any_full));
    check_val("o_ready", W'(o_ready), W'(!any_full));
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] splat(input logic [PSUM_BW-1:0] x);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*PSUM_BW +: PSUM_BW] = x;
    return v;
  endfunction

  task automatic stream(input int target);
    logic [COL-1:0] w;
    pops = 0;
    for (int cyc = 0; cyc < 5000 && pops < target; cyc++) begin
      for (int i = 0; i < COL; i++) w[i] = ($urandom_range(2) != 0);
      step(1'b0, w, rand_vec(), 1'b1);
    end
    check_val("stream_pops", W'(pops), W'(target));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pops      = 0;
    model_out = '0;
    reset     = 1'b1;
    wr        = '0;
    in        = '0;
    rd        = 1'b0;

    phase = "reset";
    step(1'b1, COL'($urandom), rand_vec(), 1'($urandom));
    step(1'b1, COL'($urandom), rand_vec(), 1'($urandom));
    step(1'b0, '0, '0, 1'b1);

    phase = "stagger";
    for (int i = 0; i < COL; i++) step(1'b0, COL'(1) << i, splat(PSUM_BW'(16'h100 + i)), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    phase = "full_lane";
    for (int k = 0; k < DEPTH; k++) step(1'b0, COL'(8'h08), splat(PSUM_BW'(k)), 1'b0);
    step(1'b0, COL'(8'h08), splat(16'hFFFF), 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, COL'(8'hF7), rand_vec(), 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1);

    phase = "ignored_rd";
    step(1'b0, COL'(8'hDF), rand_vec(), 1'b0);
    step(1'b0, COL'(8'hDF), rand_vec(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, COL'(8'h20), rand_vec(), 1'b1);
    step(1'b0, COL'(8'h20), rand_vec(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    phase = "wr_and_pop";
    for (int k = 0; k < DEPTH; k++) step(1'b0, '1, rand_vec(), 1'b0);
    step(1'b0, '1, rand_vec(), 1'b1);
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1);

    phase = "stream_a";
    stream(150);
    phase = "mid_reset";
    step(1'b1, COL'($urandom), rand_vec(), 1'($urandom));
    phase = "stream_b";
    stream(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
